frequency_band_analyzer: RTL and testbench
==========================================

# frequency_band_analyzer

Multi-band successor to the two-tone frequency analyzer. It measures the interval between qualifying edges of a 1-bit sampled signal and classifies each interval into one of `BANDS` runtime-programmable tick windows. It accumulates the ticks per band, plus an "unknown" bin, in saturating counters that are read through an indexed read port. It sits behind the sample front-end and feeds the band-statistics readout logic.

## Interface
- `BANDS`, 4: number of classification bands; must be ≥ 2. Localparam `IDX_WIDTH = $clog2(BANDS+1)`.
- `CNT_WIDTH`, 32: width of the period counter, band config and accumulators.
- `SYNC_STAGES`, 2: number of input synchroniser flops on `sample_data`; must be ≥ 2.

Ports:
- `clock`, in, 1: single clock for the whole block.
- `clear`, in, 1: reset, asynchronous, active-high.
- `sample_data`, in, 1: asynchronous input signal.
- `enable`, in, 1: measurement enable.
- `full_period`, in, 1: 0 = any edge qualifies (half-period); 1 = only rising edges qualify.
- `cfg_we`, in, 1: band config write strobe.
- `cfg_index`, in, IDX_WIDTH: band to write; values ≥ `BANDS` are ignored.
- `cfg_ticks`, in, CNT_WIDTH: band centre in ticks; 0 disables the band.
- `cfg_deviation`, in, CNT_WIDTH: band half-width in ticks.
- `acc_clear`, in, 1: synchronous clear of all accumulators and overflow flags.
- `rd_req`, in, 1: read request.
- `rd_index`, in, IDX_WIDTH: 0..`BANDS`-1 selects a band; `BANDS` selects unknown.
- `rd_data`, out, CNT_WIDTH: read result.
- `rd_valid`, out, 1: one-cycle pulse qualifying `rd_data`.
- `overflow`, out, BANDS+1: sticky saturation flag per bin; bit `BANDS` is unknown.
- `meas_valid`, out, 1: one-cycle pulse per classified interval.
- `meas_class`, out, IDX_WIDTH: band index of the last interval, or `BANDS` for unknown.
- `meas_ticks`, out, CNT_WIDTH: length of the last interval.

## Operation
- `sample_data` passes through `SYNC_STAGES` flops to give `s`. A registered copy `s_d` provides edge detection. A qualifying edge is `s != s_d` (half-period mode) or `s & ~s_d` (full-period mode).
- FSM states:
  - **IDLE**: `pcnt` is held at 0. While `enable` is high, a qualifying edge sets `pcnt <= 1` and moves to MEASURE. The partial first interval is discarded.
  - **MEASURE**: `pcnt` increments each cycle and saturates at all-ones. On a qualifying edge, the block classifies `pcnt`, accumulates it, and sets `pcnt <= 1`. If `enable` drops, `pcnt` is added to unknown, `pcnt <= 0`, and the FSM returns to IDLE.
- The measured interval equals the cycle distance between consecutive qualifying edges.
- Classification: the result is the lowest band index `b` for which all of the following hold:
  - `ticks[b] != 0`;
  - `pcnt >= lo`, where `lo = ticks - dev`, clamped to 0 when `dev > ticks`;
  - `pcnt <= hi`, where `hi = ticks + dev` is computed in CNT_WIDTH+1 bits (no wrap).
- If no band matches, the interval goes to unknown. Overlapping bands resolve to the lower index.
- Accumulators are CNT_WIDTH wide and add with saturation. When a sum would exceed all-ones, the result is held at all-ones and the bin's `overflow` bit is set (sticky).
- `full_period` and `enable` changes take effect on the next edge decision. Toggling `full_period` mid-MEASURE does not reset `pcnt`.
- Config write: when `cfg_we` is high, band `cfg_index` takes the new ticks/deviation at the clock edge. A classification in the same cycle uses the old values.
- `acc_clear` zeroes all accumulators and `overflow`. Any accumulation in the same cycle is discarded. The FSM and `pcnt` are unaffected.
- Read: `rd_req` samples `rd_index`. `rd_data` returns the accumulator value as it was before any same-cycle update. `rd_index > BANDS` returns 0 with `rd_valid` still asserted. Reads never disturb counting.
- Reset values:
  - FSM = IDLE;
  - `pcnt`, all ticks and deviations, accumulators, `overflow` = 0;
  - `rd_data`, `rd_valid`, `meas_valid`, `meas_class`, `meas_ticks` = 0;
  - synchroniser and `s_d` = 0.
- Reset asserted mid-operation aborts at once. The pending `pcnt` is not accumulated.

## Timing
- Pin-to-edge latency: `SYNC_STAGES`+1 cycles from a `sample_data` transition to the qualifying-edge cycle T.
- Accumulator update is visible at T+1. `meas_valid`, `meas_class` and `meas_ticks` are registered and valid during T+1.
- Read latency: 1 cycle. `rd_req` at cycle R gives `rd_valid` and `rd_data` at R+1. Back-to-back requests are supported, one result per cycle.
- `enable` falling at cycle E: unknown is updated at E+1 and the FSM is in IDLE at E+1.
- Throughput: one classification per cycle. Edges one cycle apart give `pcnt` = 1.

## Test plan
- **Basic bands:** band0 = 2778±277, band1 = 2272±227, half-period mode, square wave with half-period 2778 cycles for 10 edges. Expect acc0 = 9·2778 = 25002 (first interval discarded), acc1 = 0, unknown = 0, `meas_class` = 0 on each pulse.
- **Overlap and clamp:** band0 = 100±200 (lower bound clamps to 0), band1 = 150±10, interval 150. Expect the interval credited to band 0. With band0 disabled (ticks 0), the same interval goes to band 1. An interval of 500 goes to unknown.
- **Full-period mode:** `full_period` = 1, duty-cycle 30/70 wave with period 1000, band0 = 1000±5. Expect each rising-to-rising interval to add 1000 to acc0 and falling edges to be ignored.
- **Enable drop:** `enable` falls 400 cycles after the last edge. Expect unknown += 400, the FSM in IDLE, and the next edge not accumulated.
- **Saturation:** CNT_WIDTH = 8, band0 = 100±10, three intervals of 100. Expect acc0 = 255 and `overflow[0]` = 1. Then `acc_clear` coincident with an edge: expect acc0 = 0, `overflow` = 0, and that interval lost.
- **Read port and reset:** `rd_req` each cycle sweeping indices 0..`BANDS`+1. Expect correct values at R+1 and 0 for the out-of-range index. Assert `clear` mid-MEASURE: expect every output at 0 immediately.

Source files
------------

// File: rtl/frequency_band_analyzer.sv
// frequency_band_analyzer: classifies edge-to-edge intervals into programmable tick bands with saturating per-band accumulators
module frequency_band_analyzer #(
  parameter int BANDS = 4,
  parameter int CNT_WIDTH = 32,
  parameter int SYNC_STAGES = 2,
  localparam int IDX_WIDTH = $clog2(BANDS + 1)
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 sample_data,
  input  logic                 enable,
  input  logic                 full_period,
  input  logic                 cfg_we,
  input  logic [IDX_WIDTH-1:0] cfg_index,
  input  logic [CNT_WIDTH-1:0] cfg_ticks,
  input  logic [CNT_WIDTH-1:0] cfg_deviation,
  input  logic                 acc_clear,
  input  logic                 rd_req,
  input  logic [IDX_WIDTH-1:0] rd_index,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic [BANDS:0]       overflow,
  output logic                 meas_valid,
  output logic [IDX_WIDTH-1:0] meas_class,
  output logic [CNT_WIDTH-1:0] meas_ticks
);
  typedef enum logic {IDLE, MEASURE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic s_d_q, s_d_d;
  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0] ticks_q [BANDS];
  logic [CNT_WIDTH-1:0] ticks_d [BANDS];
  logic [CNT_WIDTH-1:0] dev_q [BANDS];
  logic [CNT_WIDTH-1:0] dev_d [BANDS];
  logic [CNT_WIDTH-1:0] acc_q [BANDS+1];
  logic [CNT_WIDTH-1:0] acc_d [BANDS+1];
  logic [BANDS:0] overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;
  logic meas_valid_q, meas_valid_d;
  logic [IDX_WIDTH-1:0] meas_class_q, meas_class_d;
  logic [CNT_WIDTH-1:0] meas_ticks_q, meas_ticks_d;
  logic s, qual, add_en;
  logic [IDX_WIDTH-1:0] cls, add_idx;
  logic [CNT_WIDTH:0] sum;

  function automatic logic in_band(input logic [CNT_WIDTH-1:0] p, input logic [CNT_WIDTH-1:0] t,
                                   input logic [CNT_WIDTH-1:0] d);
    logic [CNT_WIDTH-1:0] lo;
    logic [CNT_WIDTH:0] hi;
    lo = d > t ? '0 : t - d;
    hi = {1'b0, t} + {1'b0, d};
    return t != '0 && p >= lo && {1'b0, p} <= hi;
  endfunction

  assign s = sync_q[SYNC_STAGES-1];
  assign qual = full_period ? s & ~s_d_q : s ^ s_d_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sample_data};
    s_d_d = s;
  end

  // Walk from the top band down so the lowest matching index wins
  always_comb begin
    cls = IDX_WIDTH'(BANDS);
    for (int b = BANDS - 1; b >= 0; b--)
      if (in_band(pcnt_q, ticks_q[b], dev_q[b])) cls = IDX_WIDTH'(b);
  end

  always_comb begin
    state_d = state_q;
    pcnt_d = pcnt_q;
    add_en = 1'b0;
    add_idx = cls;
    meas_valid_d = 1'b0;
    meas_class_d = meas_class_q;
    meas_ticks_d = meas_ticks_q;
    if (state_q == IDLE) begin
      pcnt_d = '0;
      if (enable && qual) begin
        pcnt_d = CNT_WIDTH'(1);
        state_d = MEASURE;
      end
    end else if (!enable) begin
      add_en = 1'b1;
      add_idx = IDX_WIDTH'(BANDS);
      pcnt_d = '0;
      state_d = IDLE;
    end else if (qual) begin
      add_en = 1'b1;
      meas_valid_d = 1'b1;
      meas_class_d = cls;
      meas_ticks_d = pcnt_q;
      pcnt_d = CNT_WIDTH'(1);
    end else begin
      pcnt_d = &pcnt_q ? pcnt_q : pcnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    sum = '0;
    for (int b = 0; b <= BANDS; b++) begin
      acc_d[b] = acc_q[b];
      if (add_en && add_idx == IDX_WIDTH'(b)) begin
        sum = {1'b0, acc_q[b]} + {1'b0, pcnt_q};
        acc_d[b] = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
        overflow_d[b] = overflow_q[b] | sum[CNT_WIDTH];
      end
    end
    if (acc_clear) begin
      overflow_d = '0;
      for (int b = 0; b <= BANDS; b++) acc_d[b] = '0;
    end
  end

  always_comb begin
    for (int b = 0; b < BANDS; b++) begin
      ticks_d[b] = cfg_we && cfg_index == IDX_WIDTH'(b) ? cfg_ticks : ticks_q[b];
      dev_d[b] = cfg_we && cfg_index == IDX_WIDTH'(b) ? cfg_deviation : dev_q[b];
    end
  end

  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d = '0;
    for (int b = 0; b <= BANDS; b++)
      if (rd_req && rd_index == IDX_WIDTH'(b)) rd_data_d = acc_q[b];
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      sync_q <= '0;
      s_d_q <= 1'b0;
      pcnt_q <= '0;
      ticks_q <= '{default: '0};
      dev_q <= '{default: '0};
      acc_q <= '{default: '0};
      overflow_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      meas_valid_q <= 1'b0;
      meas_class_q <= '0;
      meas_ticks_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      s_d_q <= s_d_d;
      pcnt_q <= pcnt_d;
      ticks_q <= ticks_d;
      dev_q <= dev_d;
      acc_q <= acc_d;
      overflow_q <= overflow_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      meas_valid_q <= meas_valid_d;
      meas_class_q <= meas_class_d;
      meas_ticks_q <= meas_ticks_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;
  assign meas_valid = meas_valid_q;
  assign meas_class = meas_class_q;
  assign meas_ticks = meas_ticks_q;
endmodule

// File: tb/tb_frequency_band_analyzer.sv
// tb_frequency_band_analyzer: scoreboard bench driving a 32-bit and an 8-bit analyzer with identical stimulus
module tb_frequency_band_analyzer;
  localparam int BANDS = 4;
  localparam int IW = 3;
  localparam int LAT = 3;
  logic clock = 0, clear = 1, sample_data = 0, enable = 0, full_period = 0;
  logic cfg_we = 0, acc_clear = 0, rd_req = 0;
  logic [IW-1:0] cfg_index = 0, rd_index = 0;
  logic [31:0] cfg_ticks = 0, cfg_deviation = 0;
  logic [31:0] rd_data0, meas_ticks0;
  logic [7:0] rd_data1, meas_ticks1;
  logic rd_valid0, rd_valid1, meas_valid0, meas_valid1;
  logic [BANDS:0] overflow0, overflow1;
  logic [IW-1:0] meas_class0, meas_class1;

  frequency_band_analyzer #(.BANDS(BANDS), .CNT_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clock(clock), .clear(clear), .sample_data(sample_data), .enable(enable), .full_period(full_period),
    .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_ticks(cfg_ticks), .cfg_deviation(cfg_deviation),
    .acc_clear(acc_clear), .rd_req(rd_req), .rd_index(rd_index), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .overflow(overflow0), .meas_valid(meas_valid0), .meas_class(meas_class0), .meas_ticks(meas_ticks0));

  frequency_band_analyzer #(.BANDS(BANDS), .CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clock(clock), .clear(clear), .sample_data(sample_data), .enable(enable), .full_period(full_period),
    .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_ticks(cfg_ticks[7:0]), .cfg_deviation(cfg_deviation[7:0]),
    .acc_clear(acc_clear), .rd_req(rd_req), .rd_index(rd_index), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .overflow(overflow1), .meas_valid(meas_valid1), .meas_class(meas_class1), .meas_ticks(meas_ticks1));

  always #5 clock = ~clock;

  typedef struct { longint c; longint t; } meas_t;
  meas_t mq0[$], mq1[$];
  longint rq0[$], rq1[$];
  longint mx[2] = '{64'd4294967295, 64'd255};
  longint cfg_t[2][BANDS], cfg_d[2][BANDS], acc_m[2][BANDS+1];
  bit ovf_m[2][BANDS+1];
  longint now = 0, last = 0;
  bit meas_on = 0, en_m = 0, full_m = 0;
  int checks = 0, failures = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  function automatic longint classify(int i, longint p);
    for (int b = 0; b < BANDS; b++)
      if (cfg_t[i][b] != 0 && p + cfg_d[i][b] >= cfg_t[i][b] && p <= cfg_t[i][b] + cfg_d[i][b]) return b;
    return BANDS;
  endfunction

  function automatic logic [BANDS:0] ovf_bits(int i);
    logic [BANDS:0] v;
    for (int b = 0; b <= BANDS; b++) v[b] = ovf_m[i][b];
    return v;
  endfunction

  task automatic acc_add(int i, longint b, longint v);
    longint s;
    s = acc_m[i][b] + v;
    if (s > mx[i]) begin
      s = mx[i];
      ovf_m[i][b] = 1;
    end
    acc_m[i][b] = s;
  endtask

  task automatic model_clear_acc();
    for (int i = 0; i < 2; i++)
      for (int b = 0; b <= BANDS; b++) begin
        acc_m[i][b] = 0;
        ovf_m[i][b] = 0;
      end
  endtask

  task automatic model_edge(longint t, bit rise);
    longint iv, p, c;
    if ((full_m && !rise) || !en_m) return;
    if (!meas_on) begin
      meas_on = 1;
      last = t;
      return;
    end
    iv = t - last;
    last = t;
    for (int i = 0; i < 2; i++) begin
      p = iv < mx[i] ? iv : mx[i];
      c = classify(i, p);
      if (i == 0) mq0.push_back('{c, p});
      else mq1.push_back('{c, p});
      acc_add(i, c, p);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
    now += n;
  endtask

  task automatic toggle();
    sample_data = ~sample_data;
    model_edge(now + LAT, sample_data);
  endtask

  task automatic set_en(bit v);
    longint iv;
    enable = v;
    if (!v && meas_on) begin
      iv = now + 1 - last;
      for (int i = 0; i < 2; i++) acc_add(i, BANDS, iv < mx[i] ? iv : mx[i]);
    end
    if (!v) meas_on = 0;
    en_m = v;
  endtask

  task automatic cfg_write(int b, longint t, longint d);
    cfg_we = 1;
    cfg_index = IW'(b);
    cfg_ticks = 32'(t);
    cfg_deviation = 32'(d);
    if (b < BANDS)
      for (int i = 0; i < 2; i++) begin
        cfg_t[i][b] = t & mx[i];
        cfg_d[i][b] = d & mx[i];
      end
    step(1);
    cfg_we = 0;
  endtask

  task automatic acc_clr();
    acc_clear = 1;
    model_clear_acc();
    step(1);
    acc_clear = 0;
  endtask

  task automatic toggle_with_clear();
    sample_data = ~sample_data;
    step(2);
    acc_clear = 1;
    model_edge(now + 1, sample_data);
    model_clear_acc();
    step(1);
    acc_clear = 0;
  endtask

  task automatic read_sweep();
    for (int idx = 0; idx <= BANDS + 1; idx++) begin
      rd_req = 1;
      rd_index = IW'(idx);
      rq0.push_back(idx <= BANDS ? acc_m[0][idx] : 0);
      rq1.push_back(idx <= BANDS ? acc_m[1][idx] : 0);
      step(1);
    end
    rd_req = 0;
  endtask

  task automatic check_ovf(string n);
    chk({n, "_overflow32"}, overflow0, ovf_bits(0));
    chk({n, "_overflow8"}, overflow1, ovf_bits(1));
  endtask

  task automatic check_zero(string n);
    chk({n, "_rd_data32"}, rd_data0, 0);
    chk({n, "_rd_valid32"}, rd_valid0, 0);
    chk({n, "_meas_valid32"}, meas_valid0, 0);
    chk({n, "_meas_class32"}, meas_class0, 0);
    chk({n, "_meas_ticks32"}, meas_ticks0, 0);
    chk({n, "_overflow32"}, overflow0, 0);
    chk({n, "_rd_data8"}, rd_data1, 0);
    chk({n, "_rd_valid8"}, rd_valid1, 0);
    chk({n, "_meas_valid8"}, meas_valid1, 0);
    chk({n, "_meas_class8"}, meas_class1, 0);
    chk({n, "_meas_ticks8"}, meas_ticks1, 0);
    chk({n, "_overflow8"}, overflow1, 0);
  endtask

  always @(negedge clock) begin
    meas_t e;
    longint r;
    if (meas_valid0) begin
      if (mq0.size() == 0) begin
        checks++; failures++;
        $display("FAIL meas32_unexpected: class=%0d ticks=%0d, no interval expected", meas_class0, meas_ticks0);
      end else begin
        e = mq0.pop_front();
        chk("meas_class32", meas_class0, e.c);
        chk("meas_ticks32", meas_ticks0, e.t);
      end
    end
    if (meas_valid1) begin
      if (mq1.size() == 0) begin
        checks++; failures++;
        $display("FAIL meas8_unexpected: class=%0d ticks=%0d, no interval expected", meas_class1, meas_ticks1);
      end else begin
        e = mq1.pop_front();
        chk("meas_class8", meas_class1, e.c);
        chk("meas_ticks8", meas_ticks1, e.t);
      end
    end
    if (rd_valid0) begin
      if (rq0.size() == 0) begin
        checks++; failures++;
        $display("FAIL read32_unexpected: data=%0d, no read expected", rd_data0);
      end else begin
        r = rq0.pop_front();
        chk("rd_data32", rd_data0, r);
      end
    end
    if (rd_valid1) begin
      if (rq1.size() == 0) begin
        checks++; failures++;
        $display("FAIL read8_unexpected: data=%0d, no read expected", rd_data1);
      end else begin
        r = rq1.pop_front();
        chk("rd_data8", rd_data1, r);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    clear = 0;
    step(5);
    // basic bands, half-period square wave
    set_en(1);
    cfg_write(0, 2778, 277);
    cfg_write(1, 2272, 227);
    step(5);
    for (int n = 0; n < 10; n++) begin
      toggle();
      if (n < 9) step(2778);
    end
    step(LAT + 399);
    set_en(0);
    step(20);
    toggle();
    step(20);
    set_en(1);
    step(20);
    toggle();
    step(20);
    read_sweep();
    check_ovf("basic");
    // overlap, clamp and disabled band
    acc_clr();
    cfg_write(0, 100, 200);
    cfg_write(1, 150, 10);
    step(5);
    toggle(); step(150);
    toggle(); step(150);
    toggle(); step(10);
    cfg_write(0, 0, 0);
    step(139);
    toggle(); step(500);
    toggle(); step(10);
    read_sweep();
    // randomized bands and intervals, including an ignored out-of-range config write
    for (int b = 0; b < BANDS; b++) cfg_write(b, $urandom_range(0, 300), $urandom_range(0, 60));
    cfg_write(BANDS, 5, 5);
    step(5);
    repeat (40) begin
      toggle();
      step($urandom_range(1, 400));
    end
    step(5);
    read_sweep();
    check_ovf("random");
    // full-period mode with 30/70 duty
    acc_clr();
    cfg_write(0, 1000, 5);
    for (int b = 1; b < BANDS; b++) cfg_write(b, 0, 0);
    full_period = 1;
    full_m = 1;
    step(5);
    if (sample_data) begin
      toggle();
      step(50);
    end
    repeat (6) begin
      toggle(); step(300);
      toggle(); step(700);
    end
    step(5);
    read_sweep();
    full_period = 0;
    full_m = 0;
    // saturation then acc_clear coincident with an edge
    acc_clr();
    cfg_write(0, 100, 10);
    step(5);
    repeat (4) begin
      toggle();
      step(100);
    end
    check_ovf("saturate");
    read_sweep();
    toggle_with_clear();
    step(10);
    check_ovf("acc_clear");
    read_sweep();
    // asynchronous clear mid-measurement
    if (sample_data) begin
      toggle();
      step(20);
    end
    step(30);
    clear = 1;
    #1;
    check_zero("clear_mid");
    model_clear_acc();
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < BANDS; b++) begin
        cfg_t[i][b] = 0;
        cfg_d[i][b] = 0;
      end
    meas_on = 0;
    step(3);
    clear = 0;
    step(5);
    repeat (3) begin
      toggle();
      step(50);
    end
    step(5);
    read_sweep();
    check_ovf("after_clear");
    step(10);
    chk("meas32_drained", mq0.size(), 0);
    chk("meas8_drained", mq1.size(), 0);
    chk("read32_drained", rq0.size(), 0);
    chk("read8_drained", rq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
